next_pc_unit: RTL and testbench



---
 rtl/next_pc_unit_pkg.sv | 19 +
 rtl/next_pc_unit_bht.sv | 34 +++
 rtl/next_pc_unit.sv | 106 ++++++++++
 tb/tb_next_pc_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_unit_pkg.sv
// Shared constants and the saturating counter step for the next-PC stage.
package next_pc_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  CTR_INIT         = 2'b01;

    // Two-bit bimodal counter step, saturating at 0 and 3.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/next_pc_unit_bht.sv
// Bimodal branch history table: array of 2-bit counters, weakly not-taken on reset.
// Latency: combinational read, update lands on the next rising edge.
// Backpressure: none; updates are accepted every cycle regardless of stall.
module next_pc_unit_bht
    import next_pc_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_taken,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic            wr_taken
);

    logic [1:0] ctr [ENTRIES];

    // Read sees the pre-update value when it collides with a same-cycle write.
    assign rd_taken = ctr[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register, ID-stage branch prediction and EX-stage redirect resolution.
// Latency: redirect/flush decided combinationally, pc loads the target on the next edge.
// Backpressure: stall holds pc and defers an ID redirect; an EX redirect overrides stall.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               BHT_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic [WIDTH-1:0] id_imm,
    output logic             id_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jalr,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_imm,
    input  logic [WIDTH-1:0] ex_rs1,
    input  logic             ex_pred_taken,
    input  logic             comp,
    output logic             flush_if,
    output logic             flush_id,
    output logic             misalign
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic             bht_taken;
    logic             id_redirect;
    logic             ex_redirect;
    logic             ex_mispredict;
    logic             ex_jalr_hit;
    logic [WIDTH-1:0] id_target;
    logic [WIDTH-1:0] ex_target;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] pc_nxt;
    logic             misalign_nxt;

    next_pc_unit_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDXW    (IDXW)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (id_pc[IDXW+1:2]),
        .rd_taken (bht_taken),
        .wr_en    (ex_valid & ex_is_branch),
        .wr_idx   (ex_pc[IDXW+1:2]),
        .wr_taken (comp)
    );

    assign id_pred_taken = id_valid & id_is_branch & bht_taken;
    assign id_target     = id_pc + id_imm;
    assign id_redirect   = ~rst & id_valid & ~stall & (id_is_jal | id_pred_taken);

    assign ex_mispredict = ex_valid & ex_is_branch & (comp != ex_pred_taken);
    assign ex_jalr_hit   = ex_valid & ex_is_jalr;
    assign ex_redirect   = ~rst & (ex_mispredict | ex_jalr_hit);
    assign jalr_sum      = ex_rs1 + ex_imm;

    always_comb begin
        ex_target = ex_pc + WIDTH'(4);
        if (ex_jalr_hit) begin
            ex_target = {jalr_sum[WIDTH-1:1], 1'b0};
        end else if (comp) begin
            ex_target = ex_pc + ex_imm;
        end
    end

    assign flush_if = ex_redirect | id_redirect;
    assign flush_id = ex_redirect;

    // EX redirect shadows a simultaneous ID redirect; misalign follows whichever target loads.
    always_comb begin
        pc_nxt       = pc + WIDTH'(4);
        misalign_nxt = 1'b0;
        if (ex_redirect) begin
            pc_nxt       = ex_target;
            misalign_nxt = (ex_target[1:0] != 2'b00);
        end else if (id_redirect) begin
            pc_nxt       = id_target;
            misalign_nxt = (id_target[1:0] != 2'b00);
        end else if (stall) begin
            pc_nxt = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            misalign <= misalign_nxt;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit with hand-computed expectations.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        id_valid, id_is_branch, id_is_jal;
    logic [31:0] id_pc, id_imm;
    logic        id_pred_taken;
    logic        ex_valid, ex_is_branch, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        ex_pred_taken, comp;
    logic        flush_if, flush_id, misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    next_pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc            (pc),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_is_branch  (id_is_branch),
        .id_is_jal     (id_is_jal),
        .id_imm        (id_imm),
        .id_pred_taken (id_pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jalr    (ex_is_jalr),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_pred_taken (ex_pred_taken),
        .comp          (comp),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .misalign      (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stall = 0;
        id_valid = 0; id_pc = 0; id_is_branch = 0; id_is_jal = 0; id_imm = 0;
        ex_valid = 0; ex_is_branch = 0; ex_is_jalr = 0; ex_pc = 0; ex_imm = 0;
        ex_rs1 = 0; ex_pred_taken = 0; comp = 0;
    endtask

    task automatic set_id(input logic br, input logic jal, input logic [31:0] p, input logic [31:0] imm);
        id_valid = 1; id_is_branch = br; id_is_jal = jal; id_pc = p; id_imm = imm;
    endtask

    task automatic set_ex_br(input logic [31:0] p, input logic [31:0] imm, input logic c, input logic pred);
        ex_valid = 1; ex_is_branch = 1; ex_pc = p; ex_imm = imm; comp = c; ex_pred_taken = pred;
    endtask

    task automatic set_ex_jalr(input logic [31:0] rs1, input logic [31:0] imm);
        ex_valid = 1; ex_is_jalr = 1; ex_rs1 = rs1; ex_imm = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        clr();

        // Reset cycle 1
        @(negedge clk);
        tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_misalign", {31'b0, misalign}, 32'h0);

        // Reset cycle 2 with redirect-worthy traffic: reset must win, no BHT update
        @(negedge clk);
        set_ex_br(32'h40, 32'h20, 1'b1, 1'b0);
        set_id(1'b0, 1'b1, 32'h10, 32'h6);
        #1;
        chk("rst_flush_if", {31'b0, flush_if}, 32'h0);
        chk("rst_flush_id", {31'b0, flush_id}, 32'h0);
        tick();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_misalign", {31'b0, misalign}, 32'h0);

        // Free-run; counter[0] must still be weakly not-taken
        @(negedge clk);
        rst = 0;
        clr();
        set_id(1'b1, 1'b0, 32'h40, 32'h20);
        #1;
        chk("init_pred", {31'b0, id_pred_taken}, 32'h0);
        chk("run_flush_if", {31'b0, flush_if}, 32'h0);
        chk("run_flush_id", {31'b0, flush_id}, 32'h0);
        tick();
        chk("run_pc4", pc, 32'h4);
        @(negedge clk); clr(); tick();
        chk("run_pc8", pc, 32'h8);
        @(negedge clk); tick();
        chk("run_pc12", pc, 32'hC);

        // Predicted not-taken, actually taken at 0x40 (counter 1->2)
        @(negedge clk);
        set_ex_br(32'h40, 32'h20, 1'b1, 1'b0);
        #1;
        chk("mp_flush_if", {31'b0, flush_if}, 32'h1);
        chk("mp_flush_id", {31'b0, flush_id}, 32'h1);
        tick();
        chk("mp_pc", pc, 32'h60);
        chk("mp_misalign", {31'b0, misalign}, 32'h0);

        // Second taken resolution (correctly predicted) plus ID reading pre-update value 2
        @(negedge clk);
        clr();
        set_ex_br(32'h40, 32'h20, 1'b1, 1'b1);
        set_id(1'b1, 1'b0, 32'h40, 32'h20);
        #1;
        chk("trained_pred", {31'b0, id_pred_taken}, 32'h1);
        chk("trained_flush_if", {31'b0, flush_if}, 32'h1);
        chk("trained_flush_id", {31'b0, flush_id}, 32'h0);
        tick();
        chk("trained_pc", pc, 32'h60);

        // EX not-taken mispredict beats ID predicted-taken (counter 3->2)
        @(negedge clk);
        clr();
        set_ex_br(32'h40, 32'h20, 1'b0, 1'b1);
        set_id(1'b1, 1'b0, 32'h40, 32'h20);
        #1;
        chk("ntk_pred3", {31'b0, id_pred_taken}, 32'h1);
        chk("ntk_flush_id", {31'b0, flush_id}, 32'h1);
        tick();
        chk("ntk_pc", pc, 32'h44);

        // Correct not-taken (counter 2->1), ID still sees 2
        @(negedge clk);
        clr();
        set_ex_br(32'h40, 32'h20, 1'b0, 1'b0);
        set_id(1'b1, 1'b0, 32'h40, 32'h20);
        #1;
        chk("ok_ntk_flush_id", {31'b0, flush_id}, 32'h0);
        chk("ok_ntk_pred", {31'b0, id_pred_taken}, 32'h1);
        tick();
        chk("ok_ntk_pc", pc, 32'h60);

        // Counter now 1: no prediction
        @(negedge clk);
        clr();
        set_id(1'b1, 1'b0, 32'h40, 32'h20);
        #1;
        chk("weak_pred", {31'b0, id_pred_taken}, 32'h0);
        chk("weak_flush_if", {31'b0, flush_if}, 32'h0);
        tick();
        chk("weak_pc", pc, 32'h64);

        // JALR with odd sum clears bit 0
        @(negedge clk);
        clr();
        set_ex_jalr(32'h101, 32'h4);
        #1;
        chk("jalr_flush_if", {31'b0, flush_if}, 32'h1);
        chk("jalr_flush_id", {31'b0, flush_id}, 32'h1);
        tick();
        chk("jalr_pc", pc, 32'h104);
        chk("jalr_misalign", {31'b0, misalign}, 32'h0);

        // Misaligned JAL: misalign for exactly one cycle
        @(negedge clk);
        clr();
        set_id(1'b0, 1'b1, 32'h10, 32'h6);
        #1;
        chk("jal_flush_if", {31'b0, flush_if}, 32'h1);
        chk("jal_flush_id", {31'b0, flush_id}, 32'h0);
        tick();
        chk("jal_pc", pc, 32'h16);
        chk("jal_misalign", {31'b0, misalign}, 32'h1);
        @(negedge clk); clr(); tick();
        chk("jal_pc_next", pc, 32'h1A);
        chk("jal_misalign_drop", {31'b0, misalign}, 32'h0);

        // Stall + ID JAL + EX mispredict: EX wins
        @(negedge clk);
        stall = 1;
        set_id(1'b0, 1'b1, 32'h100, 32'h100);
        set_ex_br(32'h70, 32'h10, 1'b1, 1'b0);
        #1;
        chk("sim_flush_if", {31'b0, flush_if}, 32'h1);
        chk("sim_flush_id", {31'b0, flush_id}, 32'h1);
        tick();
        chk("sim_pc", pc, 32'h80);

        // Stall held, EX idle: hold, no ID redirect
        @(negedge clk);
        ex_valid = 0; ex_is_branch = 0;
        #1;
        chk("hold_flush_if", {31'b0, flush_if}, 32'h0);
        chk("hold_flush_id", {31'b0, flush_id}, 32'h0);
        tick();
        chk("hold_pc", pc, 32'h80);

        // Stall drops: deferred JAL fires once
        @(negedge clk);
        stall = 0;
        #1;
        chk("defer_flush_if", {31'b0, flush_if}, 32'h1);
        tick();
        chk("defer_pc", pc, 32'h200);

        // JALR target with bit 1 set raises misalign
        @(negedge clk);
        clr();
        set_ex_jalr(32'h203, 32'h0);
        tick();
        chk("jalr_mis_pc", pc, 32'h202);
        chk("jalr_mis_flag", {31'b0, misalign}, 32'h1);

        // Address wrap
        @(negedge clk);
        clr();
        set_ex_jalr(32'hFFFF_FFFC, 32'h0);
        tick();
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        @(negedge clk); clr(); tick();
        chk("wrap_pc_zero", pc, 32'h0);

        // Saturation at 3 (entry for 0x44): 1->2->3->3, then not-taken -> 2
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clr();
            set_ex_br(32'h44, 32'h0, 1'b1, 1'b1);
            tick();
        end
        @(negedge clk);
        clr();
        set_ex_br(32'h44, 32'h0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        clr();
        set_id(1'b1, 1'b0, 32'h44, 32'h8);
        #1;
        chk("sat_hi_pred", {31'b0, id_pred_taken}, 32'h1);
        tick();

        // Saturation at 0 (entry for 0x48): 1->0->0->0, then taken -> 1
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clr();
            set_ex_br(32'h48, 32'h0, 1'b0, 1'b0);
            tick();
        end
        @(negedge clk);
        clr();
        set_ex_br(32'h48, 32'h0, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        clr();
        set_id(1'b1, 1'b0, 32'h48, 32'h8);
        #1;
        chk("sat_lo_pred", {31'b0, id_pred_taken}, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
